// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered opcode decoder with load-use interlock, flush, illegal flag and stall counter
module decode_ctrl_stage #(
  parameter int INSTR_W = 9,
  parameter int OPC_W   = 3,
  parameter int REG_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               branch,
  output logic               MemToReg,
  output logic [OPC_W-1:0]   OP,
  output logic [REG_W-1:0]   out_ra,
  output logic [REG_W-1:0]   out_rb,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);
  typedef struct packed {
    logic v, rw, mr, mw, br, m2r, ill;
    logic [OPC_W-1:0] op;
    logic [REG_W-1:0] ra, rb;
  } stage_t;
  stage_t q, d;
  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra_in, rb_in;
  logic hz;
  assign opc   = instruction[INSTR_W-1 -: OPC_W];
  assign ra_in = instruction[2*REG_W-1 -: REG_W];
  assign rb_in = instruction[REG_W-1:0];
  // X/Z or out-of-range opcodes match no item and fall to the illegal default
  always_comb begin
    d    = '0;
    d.v  = 1'b1;
    d.op = opc;
    d.ra = ra_in;
    d.rb = rb_in;
    case (opc)
      OPC_W'(0), OPC_W'(1), OPC_W'(2), OPC_W'(3), OPC_W'(4): d.rw = 1'b1;
      OPC_W'(5): {d.rw, d.mr, d.m2r} = 3'b111;
      OPC_W'(6): d.mw = 1'b1;
      OPC_W'(7): d.br = 1'b1;
      default:   {d.ill, d.op} = {1'b1, {OPC_W{1'b0}}};
    endcase
  end
  assign hz       = in_valid && q.v && q.mr && (ra_in == q.ra || rb_in == q.ra);
  assign in_ready = init_n && !flush && !hz && (!q.v || out_ready);
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      q         <= '0;
      stall_cnt <= '0;
    end else begin
      q <= flush ? '0 : (in_valid && in_ready) ? d : (q.v && out_ready) ? '0 : q;
      if (hz && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  assign {out_valid, regWrite, memRead, memWrite, branch, MemToReg, illegal, OP, out_ra, out_rb} = q;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed checks of decode, hazard bubble, flush, saturation and reset
module tb_decode_ctrl_stage;
  logic clk = 1'b0, init_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic a_iv, a_ir, a_fl, a_ov, a_or, a_rw, a_mr, a_mw, a_br, a_m2r, a_ill;
  logic [8:0] a_in;
  logic [2:0] a_op, a_ra, a_rb;
  logic [7:0] a_cnt;
  logic b_iv, b_ir, b_fl, b_ov, b_or, b_rw, b_mr, b_mw, b_br, b_m2r, b_ill;
  logic [9:0] b_in;
  logic [3:0] b_op;
  logic [2:0] b_ra, b_rb;
  logic [1:0] b_cnt;
  logic [6:0] a_ctl, b_ctl, xexp;
  logic [2:0] o, xop;
  // {regWrite, memRead, memWrite, branch, MemToReg, illegal} per opcode
  logic [5:0] lut [8] = '{6'b100000, 6'b100000, 6'b100000, 6'b100000,
                          6'b100000, 6'b110010, 6'b001000, 6'b000100};
  localparam logic [6:0] ADD = 7'b1100000;
  assign a_ctl = {a_ov, a_rw, a_mr, a_mw, a_br, a_m2r, a_ill};
  assign b_ctl = {b_ov, b_rw, b_mr, b_mw, b_br, b_m2r, b_ill};

  decode_ctrl_stage u0 (
    .clk(clk), .init_n(init_n), .in_valid(a_iv), .in_ready(a_ir), .instruction(a_in),
    .flush(a_fl), .out_valid(a_ov), .out_ready(a_or), .regWrite(a_rw), .memRead(a_mr),
    .memWrite(a_mw), .branch(a_br), .MemToReg(a_m2r), .OP(a_op), .out_ra(a_ra),
    .out_rb(a_rb), .illegal(a_ill), .stall_cnt(a_cnt));

  decode_ctrl_stage #(.INSTR_W(10), .OPC_W(4), .REG_W(3), .CNT_W(2)) u1 (
    .clk(clk), .init_n(init_n), .in_valid(b_iv), .in_ready(b_ir), .instruction(b_in),
    .flush(b_fl), .out_valid(b_ov), .out_ready(b_or), .regWrite(b_rw), .memRead(b_mr),
    .memWrite(b_mw), .branch(b_br), .MemToReg(b_m2r), .OP(b_op), .out_ra(b_ra),
    .out_rb(b_rb), .illegal(b_ill), .stall_cnt(b_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_iv, a_fl, b_iv, b_fl} = '0;
    {a_or, b_or} = 2'b11;
    a_in = '0;
    b_in = '0;
    #1;
    chk("rst_ready", a_ir, 0);
    chk("rst_ctl", a_ctl, 0);
    chk("rst_op", a_op, 0);
    chk("rst_regs", {a_ra, a_rb}, 0);
    chk("rst_cnt", a_cnt, 0);
    #11 init_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i);
      a_iv = 1'b1;
      a_in = {o, o, o};
      #1 chk("stream_ready", a_ir, 1);
      tick;
      chk("stream_ctl", a_ctl, {1'b1, lut[i]});
      chk("stream_op", a_op, o);
      chk("stream_regs", {a_ra, a_rb}, {o, o});
    end
    a_iv = 1'b0;
    tick;
    chk("drain_ctl", a_ctl, 0);
    chk("drain_op", a_op, 0);
    chk("drain_regs", {a_ra, a_rb}, 0);
    chk("stream_cnt", a_cnt, 0);
    a_in = 9'bxxx_000_000;
    a_iv = 1'b1;
    tick;
    a_iv = 1'b0;
    xop = a_in[8:6];
    if ($isunknown(xop)) xexp = 7'b1000001;
    else xexp = {1'b1, lut[xop]};
    chk("xop_ctl", a_ctl, xexp);
    chk("xop_op", a_op, $isunknown(xop) ? 3'b000 : xop);
    tick;
    chk("xop_drain", a_ov, 0);
    a_iv = 1'b1;
    a_in = 9'b101_010_000;
    tick;
    a_in = 9'b100_001_010;
    #1 chk("hz_ready", a_ir, 0);
    tick;
    chk("hz_bubble", a_ov, 0);
    chk("hz_ready2", a_ir, 1);
    tick;
    chk("hz_add", a_ctl, ADD);
    chk("hz_rb", a_rb, 3'b010);
    chk("hz_cnt", a_cnt, 1);
    a_in = 9'b101_010_000;
    tick;
    a_in = 9'b100_001_011;
    #1 chk("nohz_ready", a_ir, 1);
    tick;
    chk("nohz_add", a_ctl, ADD);
    chk("nohz_cnt", a_cnt, 1);
    a_iv = 1'b0;
    tick;
    init_n = 1'b0;
    #1 chk("rst2_cnt", a_cnt, 0);
    #1 init_n = 1'b1;
    a_iv = 1'b1;
    a_in = 9'b101_010_000;
    tick;
    a_or = 1'b0;
    a_in = 9'b100_001_010;
    repeat (3) begin
      tick;
      chk("st_hold", {a_ov, a_op}, {1'b1, 3'b101});
      chk("st_ready", a_ir, 0);
    end
    chk("st_cnt", a_cnt, 3);
    a_or = 1'b1;
    tick;
    chk("st_bubble", a_ov, 0);
    chk("st_cnt4", a_cnt, 4);
    tick;
    chk("st_add", a_ctl, ADD);
    a_in = 9'b110_011_011;
    a_fl = 1'b1;
    #1 chk("fl_ready", a_ir, 0);
    tick;
    chk("fl_ctl", a_ctl, 0);
    a_fl = 1'b0;
    #1 chk("fl_ready2", a_ir, 1);
    tick;
    chk("fl_sw", a_ctl, 7'b1001000);
    chk("fl_op", a_op, 6);
    a_in = 9'b101_010_000;
    tick;
    a_in = 9'b100_001_010;
    a_fl = 1'b1;
    tick;
    chk("flhz_ov", a_ov, 0);
    chk("flhz_cnt", a_cnt, 4);
    a_fl = 1'b0;
    tick;
    chk("flhz_add", a_ctl, ADD);
    a_iv = 1'b0;
    b_iv = 1'b1;
    b_in = 10'b1000_001_010;
    tick;
    chk("b_ill_ctl", b_ctl, 7'b1000001);
    chk("b_ill_op", b_op, 0);
    b_in = 10'b0101_010_000;
    tick;
    chk("b_lw", b_ctl, 7'b1110010);
    chk("b_lw_op", b_op, 5);
    b_in = 10'b0100_001_010;
    b_or = 1'b0;
    repeat (5) tick;
    chk("b_sat", b_cnt, 3);
    chk("b_ready", b_ir, 0);
    #2 init_n = 1'b0;
    #1;
    chk("b_rst_ctl", b_ctl, 0);
    chk("b_rst_op", b_op, 0);
    chk("b_rst_regs", {b_ra, b_rb}, 0);
    chk("b_rst_cnt", b_cnt, 0);
    chk("b_rst_ready", b_ir, 0);
    chk("a_rst_ctl", a_ctl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
